// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Types and constants shared by the instruction fetch stage and its skid
// buffer.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical bubble instruction (addi x0,x0,0)
//   fetch_state_t : fetch FSM states (FETCH, WAIT, DROP)
//   ifid_t        : contents of one IF/ID slot
//   align_pc      : clears the two low bits of a byte address
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcPlus4;
    } ifid_t;

    // Word-align a byte address
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// Single-entry holding register for one IF/ID slot. It catches a fetch
// response that returns while decode is stalled.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : empty the buffer (highest priority)
//   load_i       : capture data_i and mark the buffer full
//   unload_i     : mark the buffer empty (the contents were consumed)
//   data_i       : slot to capture
//   full_o       : buffer holds an entry
//   data_o       : held entry
// -----------------------------------------------------------------------------
module fetch_skid_buffer
    import riscv_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  clear_i,
    input  logic  load_i,
    input  logic  unload_i,
    input  ifid_t data_i,
    output logic  full_o,
    output ifid_t data_o
);

    logic  full_q;
    logic  full_d;
    ifid_t data_q;
    ifid_t data_d;

    // Next-state for the full flag and the held entry
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (unload_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Buffer state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch with the IF/ID pipeline register. It keeps at most one
// word request to instruction memory outstanding. A one-entry skid buffer
// catches a response that returns while decode is stalled. A redirect
// flushes the slot, the skid buffer and any in-flight response.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   redirect_i         : taken branch/jump, load redirectTarget_i and flush
//   redirectTarget_i   : new PC (low two bits ignored)
//   stall_i            : decode cannot accept, hold the IF/ID slot
//   imemReqValid_o     : request valid
//   imemReqReady_i     : memory accepts the request
//   imemAddr_o         : request address (current PC)
//   imemRspValid_i     : response valid (one per accepted request)
//   imemRspData_i      : fetched instruction
//   valid_o            : IF/ID slot holds a real instruction
//   instr_o            : instruction to decode (NOP_INSTR when empty)
//   pc_o, pcPlus4_o    : PC of instr_o and its link value
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirectTarget_i,
    input  logic        stall_i,
    output logic        imemReqValid_o,
    input  logic        imemReqReady_i,
    output logic [31:0] imemAddr_o,
    input  logic        imemRspValid_i,
    input  logic [31:0] imemRspData_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcPlus4_o
);

    import riscv_pkg::*;

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  reqPc_q;
    logic [31:0]  reqPc_d;
    ifid_t        ifid_q;
    ifid_t        ifid_d;

    logic         reqValid_s;
    logic         reqFire_s;
    logic         deliver_s;
    logic         hold_s;
    logic         skidFull_s;
    logic         skidLoad_s;
    logic         skidUnload_s;
    ifid_t        skidData_s;
    ifid_t        deliverWord_s;

    // A full skid buffer means decode is already backed up, so no new
    // request. rst_i gates the request because the combinational path would
    // otherwise see the reset state (FETCH, skid empty) and raise valid.
    assign reqValid_s = (state_q == FETCH) && !skidFull_s && !redirect_i && !rst_i;
    assign reqFire_s  = reqValid_s && imemReqReady_i;

    // A response in WAIT is a real delivery unless a redirect kills it
    assign deliver_s  = (state_q == WAIT) && imemRspValid_i && !redirect_i;

    // Decode holds the slot only when it actually contains an instruction
    assign hold_s     = stall_i && ifid_q.valid;

    assign deliverWord_s = '{valid:   1'b1,
                             instr:   imemRspData_i,
                             pc:      reqPc_q,
                             pcPlus4: reqPc_q + 32'd4};

    assign skidLoad_s   = deliver_s && hold_s;
    assign skidUnload_s = !redirect_i && !hold_s && skidFull_s;

    fetch_skid_buffer u_skid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (redirect_i),
        .load_i   (skidLoad_s),
        .unload_i (skidUnload_s),
        .data_i   (deliverWord_s),
        .full_o   (skidFull_s),
        .data_o   (skidData_s)
    );

    // Fetch FSM next-state, PC advance and redirect
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        reqPc_d = reqPc_q;
        case (state_q)
            FETCH: begin
                if (reqFire_s) begin
                    reqPc_d = pc_q;
                    pc_d    = pc_q + 32'd4;
                    state_d = WAIT;
                end else begin
                    state_d = FETCH;
                end
            end
            WAIT: begin
                // A response ends the wait whether it is delivered or killed
                if (imemRspValid_i) begin
                    state_d = FETCH;
                end else if (redirect_i) begin
                    state_d = DROP;
                end else begin
                    state_d = WAIT;
                end
            end
            DROP: begin
                if (imemRspValid_i) begin
                    state_d = FETCH;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        if (redirect_i) begin
            pc_d = align_pc(redirectTarget_i);
        end else begin
            pc_d = pc_d;
        end
    end

    // IF/ID slot next-state: redirect > hold > skid > delivery > bubble
    always_comb begin
        ifid_d = ifid_q;
        if (redirect_i) begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
        end else if (hold_s) begin
            ifid_d = ifid_q;
        end else if (skidFull_s) begin
            ifid_d = skidData_s;
        end else if (deliver_s) begin
            ifid_d = deliverWord_s;
        end else begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
        end
    end

    // FSM, PC and IF/ID registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= FETCH;
            pc_q           <= RESET_PC;
            reqPc_q        <= RESET_PC;
            ifid_q.valid   <= 1'b0;
            ifid_q.instr   <= NOP_INSTR;
            ifid_q.pc      <= 32'h0000_0000;
            ifid_q.pcPlus4 <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            reqPc_q <= reqPc_d;
            ifid_q  <= ifid_d;
        end
    end

    assign imemReqValid_o = reqValid_s;
    assign imemAddr_o     = pc_q;
    assign valid_o        = ifid_q.valid;
    assign instr_o        = ifid_q.instr;
    assign pc_o           = ifid_q.pc;
    assign pcPlus4_o      = ifid_q.pcPlus4;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A memory model answers accepted
// requests after lat_k cycles. Every accepted request pushes its expected
// {instr, pc} onto a scoreboard. The entry is popped when decode takes the
// slot (valid_o && !stall_i). Redirects and reset flush the scoreboard.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirectTarget_i;
    logic        stall_i;
    logic        imemReqValid_o;
    logic        imemReqReady_i;
    logic [31:0] imemAddr_o;
    logic        imemRspValid_i;
    logic [31:0] imemRspData_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pcPlus4_o;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .redirect_i       (redirect_i),
        .redirectTarget_i (redirectTarget_i),
        .stall_i          (stall_i),
        .imemReqValid_o   (imemReqValid_o),
        .imemReqReady_i   (imemReqReady_i),
        .imemAddr_o       (imemAddr_o),
        .imemRspValid_i   (imemRspValid_i),
        .imemRspData_i    (imemRspData_i),
        .valid_o          (valid_o),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .pcPlus4_o        (pcPlus4_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    int          chk_cnt = 0;
    int          fail_cnt = 0;
    int          pops = 0;
    int          lat_k = 1;
    bit          pend_valid = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] model_pc = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0050_0093;
        else if (a == 32'h0000_0004) return 32'h00A0_0113;
        else return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // One clock cycle: sample at negedge, drive memory response after posedge
    task automatic tick();
        bit          acc;
        logic [31:0] acc_addr;
        exp_t        e;
        acc = 1'b0;
        acc_addr = 32'h0;
        @(negedge clk);
        if (!rst_i) begin
            if (redirect_i) begin
                sb_q.delete();
                model_pc = {redirectTarget_i[31:2], 2'b00};
            end else if (valid_o && !stall_i) begin
                check_eq("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    pops++;
                    check_eq("instr", instr_o, e.instr);
                    check_eq("pc", pc_o, e.pc);
                    check_eq("pcPlus4", pcPlus4_o, e.pc + 32'd4);
                end
            end
            if (imemReqValid_o && imemReqReady_i) begin
                check_eq("req_addr", imemAddr_o, model_pc);
                acc = 1'b1;
                acc_addr = imemAddr_o;
                sb_q.push_back('{instr: mem_word(model_pc), pc: model_pc});
                model_pc = model_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        imemRspValid_i = 1'b0;
        imemRspData_i  = 32'hDEAD_BEEF;
        if (acc) begin
            pend_valid = 1'b1;
            pend_cnt   = lat_k;
            pend_addr  = acc_addr;
        end
        if (pend_valid) begin
            if (pend_cnt <= 1) begin
                imemRspValid_i = 1'b1;
                imemRspData_i  = mem_word(pend_addr);
                pend_valid     = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !imemReqValid_o; i++) tick();
        check_eq(tag, {31'd0, imemReqValid_o}, 32'd1);
    endtask

    initial begin : main
        int          p0;
        logic [31:0] held_instr;
        logic [31:0] held_pc;
        logic [31:0] addr0;

        rst_i = 1'b1; redirect_i = 1'b0; redirectTarget_i = 32'h0; stall_i = 1'b0;
        imemReqReady_i = 1'b1; imemRspValid_i = 1'b0; imemRspData_i = 32'h0;

        // Reset values
        #2;
        check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
        check_eq("rst_instr", instr_o, NOP);
        check_eq("rst_pc", pc_o, 32'h0);
        check_eq("rst_pcPlus4", pcPlus4_o, 32'h0);
        check_eq("rst_reqValid", {31'd0, imemReqValid_o}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_i = 1'b0;

        // Basic fetch of mem[0], mem[4]
        #1;
        check_eq("first_req_valid", {31'd0, imemReqValid_o}, 32'd1);
        check_eq("first_req_addr", imemAddr_o, 32'h0);
        p0 = pops;
        repeat (6) tick();
        check_eq("basic_pops", 32'(pops - p0), 32'd2);

        // Stall while a response returns: skid catches it
        for (int i = 0; i < 10 && !valid_o; i++) tick();
        check_eq("stall_start_valid", {31'd0, valid_o}, 32'd1);
        held_instr = instr_o;
        held_pc    = pc_o;
        stall_i    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check_eq("stall_hold_instr", instr_o, held_instr);
            check_eq("stall_hold_pc", pc_o, held_pc);
            check_eq("stall_hold_valid", {31'd0, valid_o}, 32'd1);
            if (i >= 1) check_eq("stall_no_req", {31'd0, imemReqValid_o}, 32'd0);
        end
        stall_i = 1'b0;
        tick();
        #1;
        check_eq("skid_valid", {31'd0, valid_o}, 32'd1);
        check_eq("skid_pc", pc_o, held_pc + 32'd4);
        check_eq("req_after_release", {31'd0, imemReqValid_o}, 32'd1);
        repeat (3) tick();

        // Redirect to 0x100 while waiting on a slow response
        lat_k = 3;
        wait_req("redir_wait_req");
        tick();
        redirect_i = 1'b1;
        redirectTarget_i = 32'h0000_0100;
        tick();
        redirect_i = 1'b0;
        #1;
        check_eq("redir_valid", {31'd0, valid_o}, 32'd0);
        check_eq("redir_instr", instr_o, NOP);
        for (int i = 0; i < 10 && !imemReqValid_o; i++) begin
            tick();
            #1;
            check_eq("drop_bubble", {31'd0, valid_o}, 32'd0);
        end
        check_eq("redir_req_valid", {31'd0, imemReqValid_o}, 32'd1);
        check_eq("redir_addr", imemAddr_o, 32'h0000_0100);
        lat_k = 1;
        repeat (4) tick();

        // Redirect in the same cycle as the response, unaligned target
        wait_req("rr_wait_req");
        tick();
        redirect_i = 1'b1;
        redirectTarget_i = 32'h0000_0203;
        tick();
        redirect_i = 1'b0;
        #1;
        check_eq("rr_req_valid", {31'd0, imemReqValid_o}, 32'd1);
        check_eq("rr_addr", imemAddr_o, 32'h0000_0200);
        check_eq("rr_valid", {31'd0, valid_o}, 32'd0);
        repeat (4) tick();

        // Memory not ready for 3 cycles
        wait_req("rdy_wait_req");
        imemReqReady_i = 1'b0;
        addr0 = imemAddr_o;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check_eq("rdy_req_valid", {31'd0, imemReqValid_o}, 32'd1);
            check_eq("rdy_addr_stable", imemAddr_o, addr0);
        end
        imemReqReady_i = 1'b1;
        repeat (5) tick();

        // PC wrap at the top of the address space
        wait_req("wrap_wait_req");
        redirect_i = 1'b1;
        redirectTarget_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        p0 = pops;
        repeat (8) tick();
        check_eq("wrap_pops", {31'd0, (pops - p0) >= 2}, 32'd1);

        // Asynchronous reset while waiting on a response
        lat_k = 3;
        wait_req("rst_wait_req");
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("arst_valid", {31'd0, valid_o}, 32'd0);
        check_eq("arst_instr", instr_o, NOP);
        check_eq("arst_reqValid", {31'd0, imemReqValid_o}, 32'd0);
        sb_q.delete();
        pend_valid = 1'b0;
        model_pc = 32'h0;
        imemRspValid_i = 1'b0;
        lat_k = 1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        #1;
        check_eq("arst_first_req", {31'd0, imemReqValid_o}, 32'd1);
        check_eq("arst_first_addr", imemAddr_o, 32'h0);
        p0 = pops;
        repeat (6) tick();
        check_eq("arst_pops", 32'(pops - p0), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage with the IF/ID pipeline register. It holds the PC and issues word requests to instruction memory, with at most one request outstanding. It delivers instr/pc/pc+4 to decode, where instr[31:7] feeds the immediate sign-extender and the register file. A one-entry skid buffer absorbs a response that returns while decode is stalled. Redirects from branch/jump resolution flush in-flight state.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction placed on instr_o when the IF/ID slot is empty (addi x0,x0,0).

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
redirect_i  in  1  taken branch/jump; load new PC, flush
redirectTarget_i  in  32  new PC; bits [1:0] forced to 0 internally
stall_i  in  1  decode cannot accept; hold IF/ID register
imemReqValid_o  out  1  fetch request valid
imemReqReady_i  in  1  memory accepts request
imemAddr_o  out  32  request address (current PC)
imemRspValid_i  in  1  response data valid (one per accepted request, latency ≥1 cycle)
imemRspData_i  in  32  fetched instruction
valid_o  out  1  IF/ID slot holds a real instruction
instr_o  out  32  instruction to decode
pc_o  out  32  PC of instr_o
pcPlus4_o  out  32  pc_o+4 (JAL/JALR link value)

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=FETCH, skid empty, valid_o=0, instr_o=NOP_INSTR, pc_o=0, pcPlus4_o=0. imemReqValid_o is 0 while rst_i is high.
- FSM states: FETCH, WAIT, DROP.
- FETCH: imemReqValid_o = !skidFull && !redirect_i; imemAddr_o=pc. On valid&&ready: reqPc<=pc, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC→0), go to WAIT.
- WAIT: imemReqValid_o=0. On imemRspValid_i:
  - with redirect_i the same cycle, discard the response and go to FETCH;
  - otherwise deliver {imemRspData_i, reqPc} and go to FETCH.
- DROP: imemReqValid_o=0. Discard the next response, then go to FETCH.
- Delivery, when not stalled (!stall_i): IF/ID loads the delivered word directly (0-cycle bypass into the register, so the instruction is visible the cycle after the response).
- Delivery, when stalled (stall_i && valid_o): the word goes to the skid buffer; skidFull blocks new requests.
- IF/ID update when !stall_i:
  - skidFull: load from skid, then empty the skid;
  - else delivery this cycle: load it;
  - else: valid_o<=0, instr_o<=NOP_INSTR.
- IF/ID update when stall_i && valid_o: hold all IF/ID outputs.
- Skid-full and delivery in the same cycle cannot occur, because skidFull blocks requests. Verification asserts this.
- redirect_i has priority over stall_i and delivery. Next cycle:
  - pc={redirectTarget_i[31:2],2'b00}; valid_o=0; instr_o=NOP_INSTR; skid emptied.
  - State: FETCH stays FETCH; WAIT goes to DROP, or to FETCH if a response arrives that cycle; DROP stays DROP.
- No request is issued in the redirect cycle. The first request to the target goes out the cycle after.
- pcPlus4_o is always registered with pc_o, equal to pc_o+4 in 32 bits.
- Throughput: one instruction per 2 cycles with 1-cycle memory (request, then response). Pipelined multiple outstanding requests are out of scope.

Decomposition:
- Shared package riscv_pkg: NOP_INSTR constant, XLEN=32, fetch_state_t enum {FETCH,WAIT,DROP}, and struct ifid_t {valid, instr, pc, pcPlus4}.
- One sub-module, fetch_skid_buffer: a single-entry ifid_t register with load/unload/clear and a full flag.
- The PC/FSM and the IF/ID register stay in fetch_stage.

Test Plan:
- Reset then 1-cycle memory always ready, mem[0]=0x00500093, mem[4]=0x00A00113 → requests at 0x0, 0x4; valid_o with instr 0x00500093/pc 0x0/pcPlus4 0x4, then 0x00A00113/pc 0x4.
- stall_i held 4 cycles while a response returns → response captured in skid, no new request issued, IF/ID unchanged; on release the skid word appears next cycle with correct pc.
- redirect_i target 0x100 while in WAIT → next response discarded, valid_o=0 with NOP, next request addr 0x100.
- redirect_i and imemRspValid_i in the same cycle, target 0x203 → response dropped, next imemAddr_o=0x200.
- imemReqReady_i low 3 cycles → imemReqValid_o and imemAddr_o stable, pc not advanced.
- rst_i asserted mid-WAIT → outputs immediately valid_o=0, instr_o=0x13; after release, the first request is at RESET_PC and stale responses are ignored by the bench model.
